output_value_check: RTL and testbench

OUTPUT_VALUE_CHECK -- requirements
Module: output_value_check

---
 rtl/output_value_check_if.sv | 30 +++
 rtl/output_value_check.sv | 126 ++++++++++++
 tb/tb_output_value_check.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_value_check_if.sv
// Bus bundle for output_value_check: monitored values in, ASCII character stream out.
interface output_value_check_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int LED_COUNT     = 16,
  parameter int ELEMENT_COUNT = 12
);
  logic [LED_COUNT-1:0]     led_data;
  logic [ELEMENT_COUNT-1:0] element_data;
  logic                     tx_ready;
  logic [DATA_WIDTH-1:0]    output_data;
  logic                     output_valid;

  // Side that supplies the monitored values and consumes characters.
  modport master (
    output led_data,
    output element_data,
    output tx_ready,
    input  output_data,
    input  output_valid
  );

  // Side that watches the values and emits the report characters.
  modport slave (
    input  led_data,
    input  element_data,
    input  tx_ready,
    output output_data,
    output output_valid
  );
endinterface

// File: rtl/output_value_check.sv
// Watches led_data/element_data and, whenever either differs from the last
// reported value, emits one ASCII line "L<led hex>E<elem hex>\n" one
// character at a time over a valid/ready handshake.
module output_value_check #(
  parameter int DATA_WIDTH      = 8,
  parameter int CHARACTER_COUNT = 10,
  parameter int LED_COUNT       = 16,
  parameter int ELEMENT_COUNT   = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  output_value_check_if.slave  bus
);

  localparam int LED_DIGITS  = (LED_COUNT + 3) / 4;
  localparam int ELEM_DIGITS = (ELEMENT_COUNT + 3) / 4;
  localparam int LED_PAD_W   = LED_DIGITS * 4;
  localparam int ELEM_PAD_W  = ELEM_DIGITS * 4;
  localparam int IDX_W       = (CHARACTER_COUNT > 1) ? $clog2(CHARACTER_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARACTER_COUNT - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [IDX_W-1:0]         idx;
  logic [LED_COUNT-1:0]     snap_led;
  logic [ELEMENT_COUNT-1:0] snap_elem;

  logic                     changed;
  logic                     consume;
  logic                     last_char;
  logic [LED_PAD_W-1:0]     led_pad;
  logic [ELEM_PAD_W-1:0]    elem_pad;
  logic [7:0]               ascii;
  logic [3:0]               nibble;
  int                       k;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign changed   = (bus.led_data != snap_led) || (bus.element_data != snap_elem);
  assign consume   = (state == SEND) && bus.tx_ready;
  assign last_char = (idx == LAST_IDX);
  // Partial top nibbles read as zero.
  assign led_pad   = LED_PAD_W'(snap_led);
  assign elem_pad  = ELEM_PAD_W'(snap_elem);

  // State register; ena=0 freezes the FSM, reset overrides ena.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_next;
    end
  end

  // Next state: start on a detected change, finish when the last character is taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (changed) state_next = SEND;
      SEND:    if (bus.tx_ready && last_char) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshots and character index; snapshots only load in IDLE, so the line
  // in flight always describes the values that started it.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      snap_led  <= '0;
      snap_elem <= '0;
    end else if (ena) begin
      if ((state == IDLE) && changed) begin
        snap_led  <= bus.led_data;
        snap_elem <= bus.element_data;
        idx       <= '0;
      end else if (consume) begin
        idx <= last_char ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // Character decode for position idx from the snapshots.
  always_comb begin
    ascii  = 8'h00;
    nibble = '0;
    k      = int'(idx);
    if (k == 0) begin
      ascii = 8'h4C;
    end else if (k <= LED_DIGITS) begin
      nibble = led_pad[(LED_DIGITS - k) * 4 +: 4];
      ascii  = hex_ascii(nibble);
    end else if (k == LED_DIGITS + 1) begin
      ascii = 8'h45;
    end else if (k <= LED_DIGITS + 1 + ELEM_DIGITS) begin
      nibble = elem_pad[(LED_DIGITS + 1 + ELEM_DIGITS - k) * 4 +: 4];
      ascii  = hex_ascii(nibble);
    end else if (k == LED_DIGITS + ELEM_DIGITS + 2) begin
      ascii = 8'h0A;
    end
  end

  // Outputs: character only while sending; valid additionally gated by ena.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    if (state == SEND) begin
      out_valid = ena;
      out_data  = DATA_WIDTH'(ascii);
    end
  end

  assign bus.output_data  = out_data;
  assign bus.output_valid = out_valid;

endmodule

// File: tb/tb_output_value_check.sv
// Self-checking bench for output_value_check: table-driven messages, hand
// sequences for the handshake/ena/reset corner cases, and a randomized run
// compared every cycle against a queue-based message model.
module tb_output_value_check;

  localparam int LED_DIGITS  = 4;
  localparam int ELEM_DIGITS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        txr;
  logic [15:0] led;
  logic [11:0] elem;

  int checks = 0;
  int errors = 0;

  output_value_check_if #(.DATA_WIDTH(8), .LED_COUNT(16), .ELEMENT_COUNT(12)) bus ();

  assign bus.led_data     = led;
  assign bus.element_data = elem;
  assign bus.tx_ready     = txr;

  output_value_check #(
    .DATA_WIDTH(8),
    .CHARACTER_COUNT(10),
    .LED_COUNT(16),
    .ELEMENT_COUNT(12)
  ) dut (
    .clk(clk),
    .reset(rst),
    .ena(ena),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: pending characters of the current line, plus last reported values.
  logic [7:0]  mq[$];
  logic [15:0] m_led;
  logic [11:0] m_elem;
  string       HEXS = "0123456789ABCDEF";

  function automatic void build_msg(input logic [15:0] l, input logic [11:0] e);
    int n;
    mq = {};
    mq.push_back(8'h4C);
    for (int d = LED_DIGITS - 1; d >= 0; d--) begin
      n = int'((l >> (4 * d)) & 16'hF);
      mq.push_back(HEXS[n]);
    end
    mq.push_back(8'h45);
    for (int d = ELEM_DIGITS - 1; d >= 0; d--) begin
      n = int'((e >> (4 * d)) & 12'hF);
      mq.push_back(HEXS[n]);
    end
    mq.push_back(8'h0A);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    logic [7:0] exp_data;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_led  = '0;
      m_elem = '0;
    end else if (ena) begin
      if (mq.size() > 0) begin
        if (txr) void'(mq.pop_front());
      end else if (led != m_led || elem != m_elem) begin
        m_led  = led;
        m_elem = elem;
        build_msg(m_led, m_elem);
      end
    end
    #1;
    exp_data = (mq.size() > 0) ? mq[0] : 8'h00;
    chk("model_valid", {31'd0, bus.output_valid}, {31'd0, (mq.size() > 0) && ena});
    chk("model_data", {24'd0, bus.output_data}, {24'd0, exp_data});
  endtask

  function automatic logic [7:0] msg_byte(input logic [79:0] m, input int i);
    return m[79 - 8 * i -: 8];
  endfunction

  typedef struct packed {
    logic [15:0] led;
    logic [11:0] elem;
    logic [79:0] msg;
  } vec_t;

  vec_t tbl[6];

  logic [79:0] exp_msg;
  logic [79:0] got_msg;
  int          cnt;
  int          n;
  int          w;

  initial begin
    tbl[0] = '{16'hF0FF, 12'h000, "LF0FFE000\n"};
    tbl[1] = '{16'hAFCD, 12'h000, "LAFCDE000\n"};
    tbl[2] = '{16'hAFCD, 12'h123, "LAFCDE123\n"};
    tbl[3] = '{16'hAACD, 12'h123, "LAACDE123\n"};
    tbl[4] = '{16'h0000, 12'hFFF, "L0000EFFF\n"};
    tbl[5] = '{16'h1234, 12'h9AB, "L1234E9AB\n"};

    // Reset with zero inputs: silence.
    rst = 1'b1; ena = 1'b1; txr = 1'b1; led = '0; elem = '0;
    step();
    step();
    chk("reset_valid", {31'd0, bus.output_valid}, 32'd0);
    chk("reset_data", {24'd0, bus.output_data}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_after_reset", {31'd0, bus.output_valid}, 32'd0);
    end

    // Table of full messages with tx_ready held high.
    for (int v = 0; v < 6; v++) begin
      led = tbl[v].led; elem = tbl[v].elem; txr = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
        chk("tbl_valid", {31'd0, bus.output_valid}, 32'd1);
        chk("tbl_byte", {24'd0, bus.output_data}, {24'd0, msg_byte(tbl[v].msg, i)});
        step();
      end
      chk("tbl_end_idle", {31'd0, bus.output_valid}, 32'd0);
    end

    // tx_ready alternating: ten characters spread over twenty valid cycles.
    exp_msg = "L5A5AE9AB\n";
    led = 16'h5A5A; txr = 1'b0;
    step();
    cnt = 0; n = 0; got_msg = '0;
    for (int c = 0; c < 40; c++) begin
      if (!bus.output_valid) break;
      cnt++;
      if (txr && n < 10) begin
        got_msg[79 - 8 * n -: 8] = bus.output_data;
        n++;
      end
      step();
      txr = ~txr;
    end
    chk("toggle_span", cnt, 20);
    chk("toggle_bytes", n, 10);
    chk("toggle_msg_hi", got_msg[79:48], exp_msg[79:48]);
    chk("toggle_msg_lo", got_msg[47:16], exp_msg[47:16]);
    chk("toggle_msg_end", {16'd0, got_msg[15:0]}, {16'd0, exp_msg[15:0]});
    txr = 1'b1;
    step();

    // Change mid-message: current line unaffected, new line after one idle cycle.
    exp_msg = "L0F0FE9AB\n";
    led = 16'h0F0F;
    step(); step(); step(); step();
    led = 16'hBEEF;
    for (int i = 3; i < 10; i++) begin
      chk("midchg_old", {24'd0, bus.output_data}, {24'd0, msg_byte(exp_msg, i)});
      step();
    end
    chk("midchg_gap", {31'd0, bus.output_valid}, 32'd0);
    step();
    exp_msg = "LBEEFE9AB\n";
    for (int i = 0; i < 10; i++) begin
      chk("midchg_new_valid", {31'd0, bus.output_valid}, 32'd1);
      chk("midchg_new", {24'd0, bus.output_data}, {24'd0, msg_byte(exp_msg, i)});
      step();
    end
    chk("midchg_end", {31'd0, bus.output_valid}, 32'd0);

    // Change that reverts before the line ends: no follow-up line.
    led = 16'h1111;
    step(); step();
    led = 16'h2222;
    step();
    led = 16'h1111;
    w = 0;
    while (bus.output_valid && w < 20) begin
      step();
      w++;
    end
    chk("revert_line_done", {31'd0, bus.output_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("revert_no_msg", {31'd0, bus.output_valid}, 32'd0);
    end

    // ena low mid-message: valid drops, position held, resumes in place.
    exp_msg = "L1234E9AB\n";
    led = 16'h1234;
    step(); step(); step();
    chk("ena_pre", {24'd0, bus.output_data}, {24'd0, msg_byte(exp_msg, 2)});
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ena_off_valid", {31'd0, bus.output_valid}, 32'd0);
      chk("ena_off_hold", {24'd0, bus.output_data}, {24'd0, msg_byte(exp_msg, 2)});
    end
    ena = 1'b1; txr = 1'b0;
    step();
    chk("ena_resume_valid", {31'd0, bus.output_valid}, 32'd1);
    txr = 1'b1;
    for (int i = 2; i < 10; i++) begin
      chk("ena_resume", {24'd0, bus.output_data}, {24'd0, msg_byte(exp_msg, i)});
      step();
    end
    chk("ena_end", {31'd0, bus.output_valid}, 32'd0);

    // Reset at character 5 aborts; a fresh line follows reset release.
    led = 16'hC0DE;
    for (int i = 0; i < 6; i++) step();
    chk("rst_mid_pre", {31'd0, bus.output_valid}, 32'd1);
    rst = 1'b1;
    step();
    chk("rst_mid_valid", {31'd0, bus.output_valid}, 32'd0);
    chk("rst_mid_data", {24'd0, bus.output_data}, 32'd0);
    rst = 1'b0;
    step();
    exp_msg = "LC0DEE9AB\n";
    for (int i = 0; i < 10; i++) begin
      chk("rst_fresh_valid", {31'd0, bus.output_valid}, 32'd1);
      chk("rst_fresh", {24'd0, bus.output_data}, {24'd0, msg_byte(exp_msg, i)});
      step();
    end
    chk("rst_fresh_end", {31'd0, bus.output_valid}, 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      ena = ($urandom_range(0, 9) != 0);
      txr = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 19) == 0) led = 16'($urandom_range(0, 3) * 16'h1111);
      if ($urandom_range(0, 29) == 0) elem = 12'($urandom);
      step();
    end

    rst = 1'b0; ena = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
